bot_int_ctrl: RTL

Interrupt controller that sequences the RojoBot update handshakes and shares the single CPU interrupt line among several event sources. The sources are bot status update, the simulated-world tick, sensor change and the debounced buttons. It latches rising edges from each source and selects one pending, unmasked source round-robin. It then holds the interrupt until the CPU acknowledges through the AHB-lite I/O register window. It replaces the per-source set/clear handshake flops in the I/O subsystem.

---
 rtl/bot_int_pkg.sv | 14 +
 rtl/bot_int_ctrl_rr_arbiter.sv | 21 ++
 rtl/bot_int_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/bot_int_pkg.sv
// bot_int_pkg: shared register map, FSM encoding and field positions for bot_int_ctrl
package bot_int_pkg;
  localparam logic [1:0] MASK_ADDR = 2'd0;
  localparam logic [1:0] PEND_ADDR = 2'd1;
  localparam logic [1:0] VEC_ADDR  = 2'd2;
  localparam logic [1:0] ACK_ADDR  = 2'd3;
  localparam int PEND_OVR_LSB = 8;
  localparam int PEND_TO_BIT  = 16;
  localparam int VEC_ACT_BIT  = 31;
  typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_GAP} state_t;
  function automatic logic [2:0] rr_next(input logic [2:0] id, input int n);
    return 3'((int'(id) + 1) % n);
  endfunction
endpackage

// File: rtl/bot_int_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr_i
module rr_arbiter
  import bot_int_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  input  logic [2:0]   ptr_i,
  output logic [2:0]   gnt_o,
  output logic         valid_o
);
  logic [N-1:0] rot;
  int off;
  assign rot = N'({req_i, req_i} >> ptr_i);
  assign valid_o = |req_i;
  always_comb begin
    off = 0;
    for (int i = N - 1; i >= 0; i--) if (rot[i]) off = i;
    gnt_o = 3'((int'(ptr_i) + off) % N);
  end
endmodule

// File: rtl/bot_int_ctrl.sv
// bot_int_ctrl: round-robin sharing of the CPU interrupt line among edge-triggered event sources
module bot_int_ctrl
  import bot_int_pkg::*;
#(
  parameter int NSRC        = 4,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic            clk50,
  input  logic            reset,
  input  logic [NSRC-1:0] IO_Src,
  input  logic            reg_we,
  input  logic [1:0]      reg_addr,
  input  logic [31:0]     reg_wdata,
  output logic [31:0]     reg_rdata,
  output logic            IO_Irq,
  output logic [NSRC-1:0] IO_Overrun
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(ACK_TIMEOUT - 1);
  logic [NSRC-1:0] prev_q, pend_q, pend_d, ovr_q, ovr_d, mask_q, mask_d, ev, ack_clr;
  logic to_q, to_d, ack, ack_hit, to_fire, irq_q, gnt_v, unused_ok;
  logic [2:0] id_q, ptr_q, gnt;
  logic [CW-1:0] cnt_q;
  logic [31:0] pend_w, vec_w;
  state_t state_q;
  assign ev      = IO_Src & ~prev_q;
  assign ack     = reg_we && reg_addr == ACK_ADDR;
  assign ack_hit = ack && state_q == ST_ASSERT;
  assign to_fire = !ack && state_q == ST_ASSERT && cnt_q == TO_LAST;
  assign ack_clr = ack_hit ? NSRC'(1) << id_q : '0;
  // a fresh event beats the ack-clear of the same bit and is not an overrun
  assign pend_d  = (pend_q & ~ack_clr) | ev;
  assign ovr_d   = (ovr_q & ~(ack ? reg_wdata[PEND_OVR_LSB +: NSRC] : '0)) | (ev & pend_q & ~ack_clr);
  assign to_d    = (to_q & ~(ack & reg_wdata[PEND_TO_BIT])) | to_fire;
  assign mask_d  = (reg_we && reg_addr == MASK_ADDR) ? reg_wdata[NSRC-1:0] : mask_q;
  assign unused_ok = ^reg_wdata;
  rr_arbiter #(.N(NSRC)) u_arb (
    .req_i  (pend_q & mask_q),
    .ptr_i  (ptr_q),
    .gnt_o  (gnt),
    .valid_o(gnt_v)
  );
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      prev_q <= '0;
      pend_q <= '0;
      ovr_q  <= '0;
      to_q   <= 1'b0;
      mask_q <= '0;
    end else begin
      prev_q <= IO_Src;
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
      to_q   <= to_d;
      mask_q <= mask_d;
    end
  end
  // GAP arbitrates like IDLE so the line is low for exactly one cycle between requests
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_GAP: begin
          state_q <= gnt_v ? ST_ASSERT : ST_IDLE;
          irq_q   <= gnt_v;
          id_q    <= gnt_v ? gnt : id_q;
          cnt_q   <= '0;
        end
        ST_ASSERT: begin
          if (ack) begin
            state_q <= ST_GAP;
            irq_q   <= 1'b0;
            ptr_q   <= rr_next(id_q, NSRC);
          end else if (cnt_q == TO_LAST) begin
            state_q <= ST_GAP;
            irq_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          irq_q   <= 1'b0;
        end
      endcase
    end
  end
  always_comb begin
    pend_w = '0;
    pend_w[NSRC-1:0] = pend_q;
    pend_w[PEND_OVR_LSB +: NSRC] = ovr_q;
    pend_w[PEND_TO_BIT] = to_q;
    vec_w = '0;
    vec_w[VEC_ACT_BIT] = irq_q;
    vec_w[2:0] = id_q;
  end
  assign reg_rdata = reg_addr == MASK_ADDR ? {{(32 - NSRC){1'b0}}, mask_q} :
                     reg_addr == PEND_ADDR ? pend_w :
                     reg_addr == VEC_ADDR  ? vec_w : '0;
  assign IO_Irq     = irq_q;
  assign IO_Overrun = ovr_q;
endmodule
